cash_dispenser: RTL
===================

// Module: cash_dispenser
// PURPOSE
//  Downstream of the ATM transaction core. On an approved withdrawal (op_done with withdraw op),
//  the core pulses disp_req with the withdrawn amount. This block plans a greedy note breakdown
//  against limited cassette stock, then hands notes out one at a time over a valid/ack handshake.
//  It reports done or fail, and keeps the four cassette counts. Refills load through an idle-only port.
// PARAMETERS
//  AMOUNT_WIDTH  20  width of amount; matches balance_width of the core
//  COUNT_WIDTH    8  notes per cassette counter
//  DENOM0       200  highest denomination (cassette 0)
//  DENOM1       100  cassette 1
//  DENOM2        50  cassette 2
//  DENOM3        10  lowest denomination (cassette 3)
// PORTS
//  clk         in   1             system clock
//  rst         in   1             asynchronous, active-low reset
//  disp_req    in   1             1-cycle request; sampled only in IDLE
//  amount      in   AMOUNT_WIDTH  amount to dispense; captured with disp_req
//  note_valid  out  1             a note of note_type is presented
//  note_type   out  2             cassette index 0..3 of the presented note
//  note_ack    in   1             mechanism accepted the note (valid & ack = transfer)
//  busy        out  1             high in every state except IDLE
//  done        out  1             1-cycle pulse: all planned notes delivered
//  fail        out  1             1-cycle pulse: amount not payable; no notes issued
//  load_en     in   1             refill strobe; honoured only in IDLE
//  load_sel    in   2             cassette to overwrite
//  load_cnt    in   COUNT_WIDTH   new absolute count for load_sel
//  cnt0..cnt3  out  COUNT_WIDTH   current stock per cassette
// BEHAVIOUR
//  Reset: state IDLE. note_valid, note_type, busy, done and fail are 0. cnt0..3 = 0. Plan registers = 0.
//  States: IDLE -> PLAN -> {DISPENSE | FAIL}; DISPENSE -> DONE -> IDLE; FAIL -> IDLE.
//  IDLE: disp_req=1 captures amount into rem, clears plan[0..3], sets idx=0, goes to PLAN.
//   If load_en is in the same cycle, disp_req wins and load is dropped.
//   load_en alone writes cnt[load_sel] = load_cnt on the next edge.
//  PLAN: one decision per cycle.
//   If rem >= DENOM[idx] and plan[idx] < cnt[idx]: rem -= DENOM[idx], plan[idx]++.
//   Otherwise idx++.
//   When idx passes 3: rem==0 goes to DISPENSE, else goes to FAIL.
//   Latency is (total planned notes + 4) cycles. rem never underflows because the compare comes first.
//  DISPENSE: note_type = lowest index i with plan[i]!=0, with note_valid=1.
//   On note_ack: plan[i]--, cnt[i]--.
//   note_valid and note_type are registered and held stable until ack. Ack with no valid is ignored.
//   When all plan==0, including an empty plan for amount 0, go to DONE. No valid is asserted then.
//  DONE: done=1 for exactly one cycle, then IDLE. FAIL: fail=1 for one cycle, cnt unchanged, then IDLE.
//  disp_req and load_en while busy are ignored (no queueing).
//  Greedy on limited stock may fail where another mix would pay; that is a fail, by decision.
//  Amounts not a multiple of DENOM3 always fail.
//  rst low mid-operation: immediate return to reset values, including counts. The host must refill.
// STRUCTURE
//  Shared header atm_defs.vh: DENOM0..3 defaults, state encodings (IDLE, PLAN, DISPENSE, DONE, FAIL),
//   cassette index constants.
//  Single module, no sub-module. The 4-entry plan/cnt arrays and the DENOM lookup are indexed by idx.
// TESTING
//  1 Load cnt={5,5,5,5}; req 380 -> notes 0,1,2,3,3,3 in order; done; cnt={4,4,4,2}.
//  2 cnt={0,2,5,5}; req 250 -> plan 100,100,50; 3 notes; done; cnt0 stays 0.
//  3 cnt={5,5,5,5}; req 385 -> fail pulse after PLAN; no note_valid ever; counts unchanged.
//  4 cnt={1,0,0,3}; req 260 -> fail (greedy 200 + 3x10 leaves 30); counts unchanged.
//  5 req 200 with cnt0=1 and note_ack held low 10 cycles -> note_valid, type 0 held stable; then ack ->
//    done; a disp_req and load_en during busy are ignored.
//  6 req 0 -> done, no notes. Assert rst mid-DISPENSE -> all outputs 0 asynchronously; counts 0.

Source files
------------

// File: rtl/cash_dispenser_pkg.sv
// ============================================================================
//  Module  : cash_dispenser_pkg
//  Brief   : Shared constants, state encodings and helpers for the cash dispenser.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cash_dispenser_pkg;

    localparam int DEF_AMOUNT_WIDTH = 20;
    localparam int DEF_COUNT_WIDTH  = 8;
    localparam int DEF_DENOM0       = 200;
    localparam int DEF_DENOM1       = 100;
    localparam int DEF_DENOM2       = 50;
    localparam int DEF_DENOM3       = 10;
    localparam int NUM_CASSETTES    = 4;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PLAN     = 3'd1;
    localparam logic [2:0] S_DISPENSE = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_FAIL     = 3'd4;

    localparam logic [1:0] CAS0 = 2'd0;
    localparam logic [1:0] CAS1 = 2'd1;
    localparam logic [1:0] CAS2 = 2'd2;
    localparam logic [1:0] CAS3 = 2'd3;

    // Index of the lowest set bit; highest denomination with notes still owed.
    function automatic logic [1:0] lowest_set(input logic [3:0] mask);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_set = 2'(i);
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/cash_dispenser.sv
// ============================================================================
//  Module  : cash_dispenser
//  Brief   : Greedy note planner over limited cassette stock with valid/ack
//            note hand-out, done/fail pulses and idle-only refill port.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cash_dispenser
    import cash_dispenser_pkg::*;
#(
    parameter int AMOUNT_WIDTH = DEF_AMOUNT_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
    parameter int DENOM0       = DEF_DENOM0,
    parameter int DENOM1       = DEF_DENOM1,
    parameter int DENOM2       = DEF_DENOM2,
    parameter int DENOM3       = DEF_DENOM3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    disp_req,
    input  logic [AMOUNT_WIDTH-1:0] amount,
    output logic                    note_valid,
    output logic [1:0]              note_type,
    input  logic                    note_ack,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    input  logic                    load_en,
    input  logic [1:0]              load_sel,
    input  logic [COUNT_WIDTH-1:0]  load_cnt,
    output logic [COUNT_WIDTH-1:0]  cnt0,
    output logic [COUNT_WIDTH-1:0]  cnt1,
    output logic [COUNT_WIDTH-1:0]  cnt2,
    output logic [COUNT_WIDTH-1:0]  cnt3
);

    localparam logic [AMOUNT_WIDTH-1:0] DENOM [NUM_CASSETTES] = '{
        AMOUNT_WIDTH'(DENOM0), AMOUNT_WIDTH'(DENOM1),
        AMOUNT_WIDTH'(DENOM2), AMOUNT_WIDTH'(DENOM3)
    };

    state_t                  state_q, state_d;
    logic [AMOUNT_WIDTH-1:0] rem_q, rem_d;
    logic [1:0]              idx_q, idx_d;
    logic [COUNT_WIDTH-1:0]  plan_q [NUM_CASSETTES];
    logic [COUNT_WIDTH-1:0]  plan_d [NUM_CASSETTES];
    logic [COUNT_WIDTH-1:0]  cnt_q  [NUM_CASSETTES];
    logic [COUNT_WIDTH-1:0]  cnt_d  [NUM_CASSETTES];
    logic                    note_valid_q, note_valid_d;
    logic [1:0]              note_type_q, note_type_d;
    logic [NUM_CASSETTES-1:0] plan_nz;
    logic                    can_take;

    always_comb begin
        for (int i = 0; i < NUM_CASSETTES; i++) begin
            plan_nz[i] = (plan_q[i] != '0);
        end
    end

    // Compare before subtract, so rem cannot wrap.
    assign can_take = (rem_q >= DENOM[idx_q]) && (plan_q[idx_q] < cnt_q[idx_q]);

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        idx_d        = idx_q;
        plan_d       = plan_q;
        cnt_d        = cnt_q;
        note_valid_d = note_valid_q;
        note_type_d  = note_type_q;

        case (state_q)
            S_IDLE: begin
                if (disp_req) begin
                    rem_d = amount;
                    idx_d = CAS0;
                    for (int i = 0; i < NUM_CASSETTES; i++) begin
                        plan_d[i] = '0;
                    end
                    state_d = S_PLAN;
                end else if (load_en) begin
                    cnt_d[load_sel] = load_cnt;
                end
            end
            S_PLAN: begin
                if (can_take) begin
                    rem_d          = rem_q - DENOM[idx_q];
                    plan_d[idx_q]  = plan_q[idx_q] + COUNT_WIDTH'(1);
                end else if (idx_q == CAS3) begin
                    state_d = (rem_q == '0) ? S_DISPENSE : S_FAIL;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_DISPENSE: begin
                // A bubble cycle after each transfer lets the next note be chosen from settled plan counts.
                if (note_valid_q) begin
                    if (note_ack) begin
                        plan_d[note_type_q] = plan_q[note_type_q] - COUNT_WIDTH'(1);
                        cnt_d[note_type_q]  = cnt_q[note_type_q] - COUNT_WIDTH'(1);
                        note_valid_d        = 1'b0;
                    end
                end else if (|plan_nz) begin
                    note_valid_d = 1'b1;
                    note_type_d  = lowest_set(plan_nz);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE, S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            idx_q        <= '0;
            note_valid_q <= 1'b0;
            note_type_q  <= '0;
            for (int i = 0; i < NUM_CASSETTES; i++) begin
                plan_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            idx_q        <= idx_d;
            note_valid_q <= note_valid_d;
            note_type_q  <= note_type_d;
            for (int i = 0; i < NUM_CASSETTES; i++) begin
                plan_q[i] <= plan_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign note_valid = note_valid_q;
    assign note_type  = note_type_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign fail       = (state_q == S_FAIL);
    assign cnt0       = cnt_q[CAS0];
    assign cnt1       = cnt_q[CAS1];
    assign cnt2       = cnt_q[CAS2];
    assign cnt3       = cnt_q[CAS3];

endmodule

`default_nettype wire
